// File: rtl/oam_dma_controller.sv
// rtl/oam_dma_controller.sv - OAM DMA bus initiator: copies one 160-byte page into OAM at 0xFE00
module oam_dma_controller #(
  parameter int                   ADDR_SIZE = 16,
  parameter int                   DATA_SIZE = 8,
  parameter logic [ADDR_SIZE-1:0] OAM_BASE  = 16'hFE00,
  parameter int                   XFER_LEN  = 160
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 REG_WE,
  input  logic [DATA_SIZE-1:0] REG_DIN,
  output logic [DATA_SIZE-1:0] REG_DOUT,
  output logic [ADDR_SIZE-1:0] MEM_ADDR,
  output logic                 MEM_WE,
  output logic                 MEM_HOLD,
  output logic [DATA_SIZE-1:0] MEM_DOUT,
  input  logic [DATA_SIZE-1:0] MEM_DIN,
  output logic                 BUSY,
  output logic                 DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [7:0]           LAST_IDX = 8'(XFER_LEN - 1);
  localparam logic [DATA_SIZE-1:0] ECHO_LO  = DATA_SIZE'(8'hE0);
  localparam logic [DATA_SIZE-1:0] ECHO_OFS = DATA_SIZE'(8'h20);

  state_t               state_q;
  logic [7:0]           idx_q;
  logic [DATA_SIZE-1:0] src_hi_q;
  logic [DATA_SIZE-1:0] src_hi_d;
  logic [DATA_SIZE-1:0] data_q;
  logic [DATA_SIZE-1:0] reg_dout_q;
  logic                 done_q;

  // Pages 0xE0-0xFF are echo RAM; fold them down onto 0xC0-0xDF.
  always_comb begin
    src_hi_d = REG_DIN;
    if (REG_DIN >= ECHO_LO) begin
      src_hi_d = REG_DIN - ECHO_OFS;
    end
  end

  // Transfer sequencer: a register write (re)starts from index 0 in any state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      idx_q      <= 8'd0;
      src_hi_q   <= '0;
      data_q     <= '0;
      reg_dout_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (REG_WE) begin
        reg_dout_q <= REG_DIN;
        src_hi_q   <= src_hi_d;
        idx_q      <= 8'd0;
        state_q    <= START;
      end else begin
        case (state_q)
          IDLE:  state_q <= IDLE;
          START: state_q <= READ;
          READ: begin
            data_q  <= MEM_DIN;
            state_q <= WRITE;
          end
          WRITE: begin
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + 8'd1;
              state_q <= READ;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Bus drive decoded purely from registered state so reset clears it at once.
  always_comb begin
    MEM_ADDR = '0;
    MEM_WE   = 1'b0;
    MEM_HOLD = 1'b0;
    MEM_DOUT = '0;
    BUSY     = 1'b0;
    case (state_q)
      START: begin
        BUSY     = 1'b1;
        MEM_HOLD = 1'b1;
      end
      READ: begin
        BUSY     = 1'b1;
        MEM_ADDR = ADDR_SIZE'({src_hi_q, idx_q});
      end
      WRITE: begin
        BUSY     = 1'b1;
        MEM_WE   = 1'b1;
        MEM_HOLD = 1'b1;
        MEM_ADDR = OAM_BASE + ADDR_SIZE'(idx_q);
        MEM_DOUT = data_q;
      end
      default: begin
        BUSY = 1'b0;
      end
    endcase
  end

  assign REG_DOUT = reg_dout_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb/tb_oam_dma_controller.sv - self-checking bench for oam_dma_controller
module tb_oam_dma_controller;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REG_WE;
  logic [7:0]  REG_DIN;
  logic [7:0]  REG_DOUT;
  logic [15:0] MEM_ADDR;
  logic        MEM_WE;
  logic        MEM_HOLD;
  logic [7:0]  MEM_DOUT;
  logic [7:0]  mem_rd;
  logic        BUSY;
  logic        DONE;

  oam_dma_controller dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .REG_WE   (REG_WE),
    .REG_DIN  (REG_DIN),
    .REG_DOUT (REG_DOUT),
    .MEM_ADDR (MEM_ADDR),
    .MEM_WE   (MEM_WE),
    .MEM_HOLD (MEM_HOLD),
    .MEM_DOUT (MEM_DOUT),
    .MEM_DIN  (mem_rd),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Memory model: write on posedge, read data refreshed on negedge unless held.
  logic [7:0]  mem [65536];
  logic        fill_we;
  logic [15:0] fill_addr;
  logic [7:0]  fill_data;

  always @(posedge CLK) begin
    if (MEM_WE) mem[MEM_ADDR] = MEM_DOUT;
    else if (fill_we) mem[fill_addr] = fill_data;
  end

  always @(negedge CLK) begin
    if (!MEM_HOLD) mem_rd <= mem[MEM_ADDR];
  end

  // Cycle bookkeeping: cycle p+1 is the interval after posedge number p.
  int cyc = 0;
  int busy_cnt = 0;
  int done_cyc[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (BUSY) busy_cnt = busy_cnt + 1;
    if (DONE) done_cyc.push_back(cyc + 1);
  end

  // Reference data: what each source page holds, and OAM before a partial copy.
  logic [7:0] ref_pg [256][160];
  logic [7:0] oam_old [160];

  function automatic logic [7:0] remap(input logic [7:0] v);
    return (v >= 8'hE0) ? v - 8'h20 : v;
  endfunction

  function automatic int done_at(input int i);
    return (done_cyc.size() > i) ? done_cyc[i] : -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] a, input logic [7:0] d);
    @(negedge CLK);
    fill_addr = a;
    fill_data = d;
    fill_we   = 1'b1;
    @(negedge CLK);
    fill_we   = 1'b0;
  endtask

  task automatic fill_page(input logic [7:0] pg, input bit rnd);
    logic [7:0] v;
    for (int i = 0; i < 160; i++) begin
      v = rnd ? 8'($urandom) : (8'(i) ^ 8'h5A);
      ref_pg[pg][i] = v;
      fill({pg, 8'(i)}, v);
    end
  endtask

  task automatic check_oam(input string tag, input logic [7:0] pg, input int upto);
    for (int i = 0; i < 160; i++) begin
      chk(tag, {24'd0, mem[16'hFE00 + 16'(i)]}, {24'd0, (i < upto) ? ref_pg[pg][i] : oam_old[i]});
    end
  endtask

  // Start a transfer, then watch 'total' cycles; optional restart / reset at cycle k+n.
  task automatic run(input logic [7:0] din, input int total, input int rn,
                     input logic [7:0] din2, input int rstn, input bit chk_bus,
                     output int k);
    logic [7:0] pg;
    int         idx;
    pg = remap(din);
    @(negedge CLK);
    REG_DIN = din;
    REG_WE  = 1'b1;
    @(posedge CLK);
    #1;
    k      = cyc;
    REG_WE = 1'b0;
    for (int n = 1; n <= total; n++) begin
      @(negedge CLK);
      if (chk_bus && n == 1) begin
        chk("start_addr", {16'd0, MEM_ADDR}, 32'h0);
        chk("start_we", {31'd0, MEM_WE}, 32'd0);
        chk("start_hold", {31'd0, MEM_HOLD}, 32'd1);
        chk("start_busy", {31'd0, BUSY}, 32'd1);
      end
      if (chk_bus && n >= 2 && n <= 5) begin
        idx = (n - 2) / 2;
        if (n % 2 == 0) begin
          chk("rd_addr", {16'd0, MEM_ADDR}, pg * 256 + idx);
          chk("rd_we", {31'd0, MEM_WE}, 32'd0);
          chk("rd_hold", {31'd0, MEM_HOLD}, 32'd0);
        end else begin
          chk("wr_addr", {16'd0, MEM_ADDR}, 32'hFE00 + idx);
          chk("wr_we", {31'd0, MEM_WE}, 32'd1);
          chk("wr_hold", {31'd0, MEM_HOLD}, 32'd1);
          chk("wr_data", {24'd0, MEM_DOUT}, {24'd0, ref_pg[pg][idx]});
        end
      end
      REG_WE = (n == rn);
      if (n == rn) REG_DIN = din2;
      if (n == rstn) begin
        RST_N = 1'b0;
        #1;
        chk("rst_mem_we", {31'd0, MEM_WE}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
      end
    end
    REG_WE = 1'b0;
    RST_N  = 1'b1;
  endtask

  int         k;
  int         b0;
  int         d0;
  logic [7:0] din;

  initial begin
    RST_N     = 1'b0;
    REG_WE    = 1'b0;
    REG_DIN   = 8'h00;
    fill_we   = 1'b0;
    fill_addr = 16'h0;
    fill_data = 8'h0;
    repeat (3) @(negedge CLK);
    chk("reset_mem_we", {31'd0, MEM_WE}, 32'd0);
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    chk("reset_done", {31'd0, DONE}, 32'd0);
    chk("reset_addr", {16'd0, MEM_ADDR}, 32'h0);
    chk("reset_reg_dout", {24'd0, REG_DOUT}, 32'h0);
    chk("reset_hold", {31'd0, MEM_HOLD}, 32'd0);
    chk("reset_mem_dout", {24'd0, MEM_DOUT}, 32'h0);
    RST_N = 1'b1;

    fill(16'hFEA0, 8'h77);

    // Basic copy from page C1 with the i^0x5A pattern.
    fill_page(8'hC1, 1'b0);
    b0 = busy_cnt; d0 = done_cyc.size();
    run(8'hC1, 330, 0, 8'h00, 0, 1'b1, k);
    chk("basic_busy_len", busy_cnt - b0, 321);
    chk("basic_done_count", done_cyc.size() - d0, 1);
    chk("basic_done_cycle", done_at(d0) - k, 322);
    chk("basic_reg_dout", {24'd0, REG_DOUT}, 32'hC1);
    check_oam("basic_oam", 8'hC1, 160);
    chk("basic_sentinel", {24'd0, mem[16'hFEA0]}, 32'h77);

    // Echo region: E2 reads page C2, readback keeps the raw value.
    fill_page(8'hC2, 1'b1);
    run(8'hE2, 330, 0, 8'h00, 0, 1'b1, k);
    chk("echo_reg_dout", {24'd0, REG_DOUT}, 32'hE2);
    check_oam("echo_oam", 8'hC2, 160);

    // Random source pages.
    for (int t = 0; t < 3; t++) begin
      din = 8'($urandom);
      fill_page(remap(din), 1'b1);
      b0 = busy_cnt; d0 = done_cyc.size();
      run(din, 330, 0, 8'h00, 0, 1'b0, k);
      chk("rand_busy_len", busy_cnt - b0, 321);
      chk("rand_done_cycle", done_at(d0) - k, 322);
      chk("rand_reg_dout", {24'd0, REG_DOUT}, {24'd0, din});
      check_oam("rand_oam", remap(din), 160);
    end

    // Restart at k+100 onto page D0.
    fill_page(8'hC1, 1'b1);
    fill_page(8'hD0, 1'b1);
    b0 = busy_cnt; d0 = done_cyc.size();
    run(8'hC1, 430, 100, 8'hD0, 0, 1'b0, k);
    chk("restart_busy_len", busy_cnt - b0, 421);
    chk("restart_done_count", done_cyc.size() - d0, 1);
    chk("restart_done_cycle", done_at(d0) - (k + 100), 322);
    check_oam("restart_oam", 8'hD0, 160);

    // Restart on the edge that closes the final write: no DONE for the first.
    fill_page(8'h40, 1'b1);
    fill_page(8'h41, 1'b1);
    b0 = busy_cnt; d0 = done_cyc.size();
    run(8'h40, 650, 321, 8'h41, 0, 1'b0, k);
    chk("lastedge_busy_len", busy_cnt - b0, 642);
    chk("lastedge_done_count", done_cyc.size() - d0, 1);
    chk("lastedge_done_cycle", done_at(d0) - k, 643);
    check_oam("lastedge_oam", 8'h41, 160);

    // Start issued while DONE is high: pulse still one cycle, new run normal.
    fill_page(8'h12, 1'b1);
    fill_page(8'h13, 1'b1);
    b0 = busy_cnt; d0 = done_cyc.size();
    run(8'h12, 650, 322, 8'h13, 0, 1'b0, k);
    chk("donehi_busy_len", busy_cnt - b0, 642);
    chk("donehi_done_count", done_cyc.size() - d0, 2);
    chk("donehi_done0", done_at(d0) - k, 322);
    chk("donehi_done1", done_at(d0 + 1) - k, 644);
    check_oam("donehi_oam", 8'h13, 160);

    // Reset during READ of idx 50, then during WRITE of idx 50.
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 160; i++) begin
        oam_old[i] = 8'($urandom);
        fill(16'hFE00 + 16'(i), oam_old[i]);
      end
      din = 8'($urandom_range(0, 8'hDF));
      fill_page(din, 1'b1);
      d0 = done_cyc.size();
      run(din, 110, 0, 8'h00, 102 + t, 1'b0, k);
      repeat (3) @(negedge CLK);
      chk("postrst_busy", {31'd0, BUSY}, 32'd0);
      chk("postrst_addr", {16'd0, MEM_ADDR}, 32'h0);
      chk("postrst_done_count", done_cyc.size() - d0, 0);
      check_oam("postrst_oam", din, 50);
    end

    chk("final_sentinel", {24'd0, mem[16'hFEA0]}, 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
Bus initiator implementing the FF46 OAM DMA transfer. A write to the DMA register copies 160 bytes from {SRC,8'h00} into OAM at 0xFE00-0xFE9F. It drives the same synchronous memory interface the CPU uses: ADDR/WE/DIN/DOUT/HOLD, with write on posedge and read data updated on negedge. BUSY asserts while the DMA owns the bus, and the top-level mux hands it the memory port.

Parameters:
ADDR_SIZE, 16, memory address width
DATA_SIZE, 8, memory data width
OAM_BASE, 16'hFE00, destination base address
XFER_LEN, 160, bytes per transfer

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous reset, active-low
REG_WE  input  1  CPU write strobe to FF46, sampled on posedge
REG_DIN  input  DATA_SIZE  CPU write data (source high byte)
REG_DOUT  output  DATA_SIZE  last value written to FF46 (readback)
MEM_ADDR  output  ADDR_SIZE  address to memory
MEM_WE  output  1  memory write enable
MEM_HOLD  output  1  memory read-hold (freezes memory DOUT)
MEM_DOUT  output  DATA_SIZE  write data to memory DIN
MEM_DIN  input  DATA_SIZE  read data from memory DOUT
BUSY  output  1  DMA owns bus (any state except IDLE)
DONE  output  1  one-cycle pulse after a completed transfer

Behaviour:
- Reset (async, RST_N=0): state=IDLE, idx=0, src_hi=0, data_q=0, REG_DOUT=0x00, DONE=0.
- Outputs in reset: MEM_WE=0, MEM_HOLD=0, MEM_ADDR=0, MEM_DOUT=0, BUSY=0.
- MEM_WE must fall immediately on reset assertion. MEM_* and BUSY are combinational decodes of registered state, idx and data_q only.
- Source remap: src_hi = REG_DIN. Values 0xE0-0xFF are replaced by REG_DIN-0x20 (echo region). REG_DOUT always holds the raw REG_DIN.
- States:
  - IDLE: MEM_WE=0, HOLD=0, ADDR=0, BUSY=0.
  - START: one-cycle setup. BUSY=1, WE=0, HOLD=1, ADDR=0. Next state is READ.
  - READ: ADDR={src_hi, idx[7:0]}, WE=0, HOLD=0. Memory updates its DOUT at the mid-cycle negedge. At the closing posedge, data_q<=MEM_DIN. Next state is WRITE.
  - WRITE: ADDR=OAM_BASE+idx, WE=1, HOLD=1, MEM_DOUT=data_q. At the closing posedge:
    - if idx==XFER_LEN-1: go to IDLE, DONE<=1 for one cycle;
    - else: idx<=idx+1, go to READ.
- Timing for a REG_WE sampled at posedge k:
  - cycle k+1 is START;
  - the first READ is cycle k+2;
  - the last WRITE ends at posedge k+321;
  - BUSY is high for exactly 321 cycles;
  - DONE is high during cycle k+322.
- Throughput: 2 cycles per byte, XFER_LEN*2+1 cycles per transfer.
- idx is 8 bits wide and never exceeds XFER_LEN-1. No wrap into 0xFEA0 or above.
- Restart: REG_WE in any non-IDLE state latches the new src_hi, sets idx<=0 and goes to START.
  - A WRITE in progress at that edge still completes, since the memory has already sampled WE=1.
  - The aborted transfer produces no DONE.
  - REG_WE on the same edge as the final WRITE: that write completes, the restart wins, and DONE is not pulsed.
- REG_WE in IDLE while DONE is high is legal: it starts normally and DONE still drops after one cycle.
- Reset mid-transfer: immediate return to IDLE. Bytes already written remain in OAM; no further writes occur.

Test Plan:
- Reset: hold RST_N=0 with CLK running -> MEM_WE=0, BUSY=0, DONE=0, MEM_ADDR=0x0000, REG_DOUT=0x00.
- Basic copy: preload 0xC100+i = i^0x5A for i=0..159, pulse REG_WE with 0xC1 -> OAM 0xFE00+i = i^0x5A; BUSY high 321 cycles; single DONE pulse at cycle k+322; 0xFEA0 unchanged.
- Bus sequence: same start -> cycles k+2..k+5 show:
  - ADDR/WE/HOLD = C100/0/0, FE00/1/1, C101/0/0, FE01/1/1;
  - MEM_DOUT in the FE00 cycle equals mem[0xC100].
- Echo remap: REG_DIN=0xE2 -> reads from 0xC200-0xC29F; REG_DOUT reads back 0xE2.
- Restart: write 0xC1, then write 0xD0 at cycle k+100 -> final OAM holds all 160 bytes of the 0xD000 block; BUSY is continuous; exactly one DONE, 321 cycles after the restart edge.
- Reset mid-op: assert RST_N=0 during READ of idx=50 -> MEM_WE drops in the same cycle; OAM 0..49 updated, 50..159 untouched; after release, state is IDLE with BUSY=0.
